sid_reg_scheduler: RTL and testbench
====================================

// Module: sid_reg_scheduler
// PURPOSE
//  Sole writer of the sid8580 register port (we/addr/data_in). Arbitrates between
//  the C64 CPU bus (hard priority, never stalled) and a host write queue used for
//  register injection (e.g. loader/player/OSD). Host writes are buffered in a FIFO
//  and paced onto ce_1m ticks with a minimum spacing, so the SID sees one write per slot.
// PARAMETERS
//  DEPTH      16  host FIFO entries (power of 2, >=2)
//  GAP_TICKS  2   min ce_1m ticks between consecutive host writes (>=1)
// PORTS
//  clk         in   1  system clock
//  reset       in   1  synchronous, active-high
//  ce_1m       in   1  1 MHz clock-enable pulse (one clk wide)
//  cpu_cs      in   1  CPU selects SID this clk
//  cpu_we      in   1  CPU write strobe (qualified by cpu_cs)
//  cpu_addr    in   5  CPU register address
//  cpu_din     in   8  CPU write data
//  host_valid  in   1  host write request
//  host_ready  out  1  FIFO can accept (transfer = valid & ready)
//  host_addr   in   5  host register address
//  host_data   in   8  host write data
//  flush       in   1  drop all queued host writes
//  sid_we      out  1  to sid8580 we
//  sid_addr    out  5  to sid8580 addr
//  sid_data    out  8  to sid8580 data_in
//  fifo_level  out  $clog2(DEPTH)+1  queued host entries (0..DEPTH)
//  busy        out  1  fifo_level!=0 or gap counter!=0
// BEHAVIOUR
//  - Reset: sid_we=0, sid_addr=0, sid_data=0, fifo empty, fifo_level=0, host_ready=1,
//    busy=0, gap=0, state=IDLE. Reset mid-operation discards queue and any pending write.
//  - All sid_* outputs registered; sid_we is a single-clk pulse.
//  - CPU write: cpu_cs&cpu_we in cycle N -> sid_we=1, sid_addr=cpu_addr, sid_data=cpu_din
//    in cycle N+1. Always accepted, regardless of ce_1m, FIFO or gap state.
//  - CPU read / idle: sid_addr <= cpu_addr every non-write cycle (read data valid at N+1);
//    sid_data holds last value.
//  - FIFO: push on host_valid&host_ready; host_ready = (fifo_level<DEPTH) from registered
//    count, so no push when full even if a pop occurs the same cycle. Simultaneous push
//    and pop when non-full: level unchanged. Pointers wrap modulo DEPTH.
//  - FSM IDLE: if ce_1m & fifo non-empty & gap==0 & no CPU write this cycle -> pop head,
//    next cycle sid_we=1 with head addr/data; gap<=GAP_TICKS; -> WAIT_GAP.
//  - FSM WAIT_GAP: each ce_1m decrements gap; gap reaching 0 -> IDLE. Issue eligibility
//    re-evaluated at the first ce_1m with gap==0 (so GAP_TICKS=2 => host writes >=2 ticks apart).
//  - Collision: CPU write in the same cycle as an eligible host slot -> CPU issued, host
//    pop deferred to next eligible ce_1m; nothing is lost, FIFO order preserved.
//  - flush: clears FIFO (level 0, pointers 0) next cycle; gap counter and FSM unaffected;
//    flush wins over a same-cycle push (pushed entry dropped); does not cancel a CPU write.
//  - host_addr >0x18 passes through unchanged (sid8580 ignores it).
// TESTING
//  1 Reset then idle: all outputs 0, host_ready=1, busy=0; cpu_addr=0x1B read -> sid_addr=0x1B next clk.
//  2 CPU write 0x18<=0x0F -> sid_we=1,addr=0x18,data=0x0F exactly one clk later, no ce_1m needed.
//  3 Push 3 host writes (0x00<=0x11,0x01<=0x22,0x04<=0x21), GAP_TICKS=2 -> issued in order on
//    ticks T,T+2,T+4; fifo_level 3->0; busy falls after final gap expires.
//  4 Fill DEPTH=16 entries -> host_ready=0, 17th valid held unaccepted; one pop -> ready=1 next clk.
//  5 CPU write coincident with eligible host tick -> CPU write issued, host write issues at
//    next ce_1m; both appear once, queue order intact.
//  6 flush with 5 queued plus same-cycle push -> fifo_level=0, no host sid_we afterwards; reset
//    asserted mid WAIT_GAP -> all outputs to reset values next clk.

Source files
------------

// File: rtl/sid_reg_scheduler.sv
// Sole writer of the sid8580 register port: CPU writes pass straight through,
// host writes are queued and paced onto ce_1m ticks with a minimum spacing.
module sid_reg_scheduler #(
  parameter int DEPTH     = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce_1m,
  input  logic                     cpu_cs,
  input  logic                     cpu_we,
  input  logic [4:0]               cpu_addr,
  input  logic [7:0]               cpu_din,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [4:0]               host_addr,
  input  logic [7:0]               host_data,
  input  logic                     flush,
  output logic                     sid_we,
  output logic [4:0]               sid_addr,
  output logic [7:0]               sid_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_TICKS + 1);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [GW-1:0] GAP  = GW'(GAP_TICKS);
  localparam logic [GW-1:0] ONE  = GW'(1);

  typedef enum logic {IDLE, WAIT_GAP} state_t;

  state_t        state, state_nx;
  logic [GW-1:0] gap, gap_nx;
  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic [12:0]   head;
  logic          cpu_wr, slot, pop, push;

  assign cpu_wr     = cpu_cs & cpu_we;
  assign host_ready = cnt < FULL;
  assign fifo_level = cnt;
  assign busy       = (cnt != '0) | (gap != '0);
  assign head       = mem[rp];

  // The tick that drains the gap is itself a usable slot
  assign slot = ce_1m & ((state == IDLE) | (gap == ONE));
  assign pop  = slot & (cnt != '0) & ~cpu_wr & ~flush;
  assign push = host_valid & host_ready & ~flush;

  always_comb begin
    state_nx = state;
    gap_nx   = gap;
    unique case (state)
      IDLE: begin
        if (pop) begin
          gap_nx   = GAP;
          state_nx = WAIT_GAP;
        end
      end
      WAIT_GAP: begin
        if (pop) begin
          gap_nx = GAP;
        end else if (ce_1m) begin
          gap_nx = gap - ONE;
          if (gap == ONE) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      gap   <= '0;
    end else begin
      state <= state_nx;
      gap   <= gap_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= {host_addr, host_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sid_we   <= 1'b0;
      sid_addr <= '0;
      sid_data <= '0;
    end else begin
      sid_we <= 1'b0;
      unique case (1'b1)
        cpu_wr: begin
          sid_we   <= 1'b1;
          sid_addr <= cpu_addr;
          sid_data <= cpu_din;
        end
        pop: begin
          sid_we   <= 1'b1;
          sid_addr <= head[12:8];
          sid_data <= head[7:0];
        end
        default: sid_addr <= cpu_addr;
      endcase
    end
  end
endmodule

// File: tb/tb_sid_reg_scheduler.sv
// Randomized scoreboard bench for sid_reg_scheduler against a tick-count
// reference model of the host pacing and a plain queue for the FIFO.
module tb_sid_reg_scheduler;
  localparam int DEPTH = 16;
  localparam int GAP   = 2;
  localparam int NCYC  = 4200;

  logic       clk = 0;
  logic       reset = 1;
  logic       ce_1m = 0;
  logic       cpu_cs = 0, cpu_we = 0;
  logic [4:0] cpu_addr = 0;
  logic [7:0] cpu_din = 0;
  logic       host_valid = 0;
  logic       host_ready;
  logic [4:0] host_addr = 0;
  logic [7:0] host_data = 0;
  logic       flush = 0;
  logic       sid_we;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic [4:0] fifo_level;
  logic       busy;

  sid_reg_scheduler #(.DEPTH(DEPTH), .GAP_TICKS(GAP)) dut (
    .clk(clk), .reset(reset), .ce_1m(ce_1m),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_data(host_data),
    .flush(flush), .sid_we(sid_we),
    .sid_addr(sid_addr), .sid_data(sid_data),
    .fifo_level(fifo_level), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] data;
    int         level;
    logic       ready;
    logic       busy;
  } st_t;

  typedef struct {
    int         cyc;
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;

  st_t stq[$];
  wr_t wq[$];
  int  vecs = 0;
  int  errs = 0;
  int  cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cycle %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against queued expectations
  always begin
    @(posedge clk);
    #1;
    if (stq.size() > 0) begin
      st_t s;
      s = stq.pop_front();
      chk("sid_we", 32'(sid_we), 32'(s.we));
      chk("sid_addr", 32'(sid_addr), 32'(s.addr));
      chk("sid_data", 32'(sid_data), 32'(s.data));
      chk("fifo_level", 32'(fifo_level), 32'(s.level));
      chk("host_ready", 32'(host_ready), 32'(s.ready));
      chk("busy", 32'(busy), 32'(s.busy));
    end
    if (sid_we === 1'b1) begin
      if (wq.size() == 0) begin
        chk("spurious_write", 32'(sid_addr), 32'hFFFF);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(w.cyc));
        chk("wr_addr", 32'(sid_addr), 32'(w.a));
        chk("wr_data", 32'(sid_data), 32'(w.d));
      end
    end else if (wq.size() > 0 && wq[0].cyc <= cyc) begin
      wr_t w;
      w = wq.pop_front();
      chk("missing_write", 32'(sid_we), 32'(1));
    end
  end

  // Reference model state
  logic [12:0] hq[$];
  int          tcnt = 0;
  int          last_t = 0;
  bit          issued = 0;
  logic [7:0]  last_data = 0;

  task automatic model_step();
    st_t  s;
    logic cw, elig;
    int   sz;
    if (reset) begin
      hq.delete();
      issued    = 0;
      tcnt      = 0;
      last_data = 0;
      s = '{we: 0, addr: 0, data: 0, level: 0, ready: 1, busy: 0};
      stq.push_back(s);
      return;
    end
    cw = cpu_cs & cpu_we;
    if (ce_1m) tcnt++;
    sz   = hq.size();
    elig = ce_1m && sz > 0 && !cw && !flush &&
           (!issued || (tcnt - last_t) >= GAP);
    s.ready = (sz < DEPTH);
    if (cw) begin
      s.we = 1; s.addr = cpu_addr; s.data = cpu_din;
      wq.push_back('{cyc: cyc + 1, a: cpu_addr, d: cpu_din});
    end else if (elig) begin
      logic [12:0] h;
      h = hq.pop_front();
      issued = 1;
      last_t = tcnt;
      s.we = 1; s.addr = h[12:8]; s.data = h[7:0];
      wq.push_back('{cyc: cyc + 1, a: h[12:8], d: h[7:0]});
    end else begin
      s.we = 0; s.addr = cpu_addr; s.data = last_data;
    end
    if (flush) hq.delete();
    else if (host_valid && s.ready) hq.push_back({host_addr, host_data});
    last_data = s.data;
    s.level = hq.size();
    s.ready = (hq.size() < DEPTH);
    s.busy  = (hq.size() != 0) || (issued && (tcnt - last_t) < GAP);
    stq.push_back(s);
  endtask

  initial begin
    int p_push, p_cpu, p_flush, tlo, thi, tk;
    tk = 0;
    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      if (i < 800)       begin p_push = 70; p_cpu = 5;  p_flush = 0; tlo = 8; thi = 12; end
      else if (i < 1600) begin p_push = 20; p_cpu = 20; p_flush = 1; tlo = 2; thi = 4;  end
      else if (i < 2600) begin p_push = 50; p_cpu = 30; p_flush = 2; tlo = 1; thi = 3;  end
      else if (i < 4000) begin p_push = 10; p_cpu = 5;  p_flush = 0; tlo = 3; thi = 6;  end
      else               begin p_push = 0;  p_cpu = 0;  p_flush = 0; tlo = 2; thi = 3;  end
      reset = (i < 3) || (i == 1600);
      if (tk == 0) begin
        ce_1m = 1;
        tk = $urandom_range(thi, tlo) - 1;
      end else begin
        ce_1m = 0;
        tk--;
      end
      cpu_cs     = ($urandom_range(99) < 50);
      cpu_we     = cpu_cs && ($urandom_range(99) < 2 * p_cpu);
      cpu_addr   = 5'($urandom);
      cpu_din    = 8'($urandom);
      host_valid = ($urandom_range(99) < p_push);
      host_addr  = 5'($urandom);
      host_data  = 8'($urandom);
      flush      = ($urandom_range(99) < p_flush);
      model_step();
    end
    @(negedge clk);
    reset = 0; ce_1m = 0; cpu_cs = 0; cpu_we = 0;
    host_valid = 0; flush = 0;
    model_step();
    @(negedge clk);
    @(negedge clk);
    chk("write_queue_drained", 32'(wq.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
